// File: rtl/crop_pkg.sv
// crop_pkg - shared definitions for the crop_filter / uncrop_pad pair.
//
// Contents:
//   coord_width(n)    : bits needed to count 0..n-1 (minimum 1)
//   DEFAULT_PAD_VALUE : pixel value used outside a crop window by default
//   window_fits(...)  : true when a crop window lies fully inside its frame,
//                       used for elaboration-time parameter checks
package crop_pkg;

    localparam int DEFAULT_PAD_VALUE = 0;

    function automatic int coord_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // One axis at a time: origin and size of the crop against the frame size.
    function automatic bit window_fits(input int frame_n, input int origin, input int crop_n);
        return (crop_n >= 1) && (origin >= 0) && (origin + crop_n <= frame_n);
    endfunction

endpackage

// File: rtl/uncrop_pad_if.sv
// uncrop_pad_if - valid/ready pixel stream bundle for uncrop_pad.
//
// Input side : pixel_in, in_valid (to block), in_ready (from block)
// Output side: pixel_out, out_valid, frame_last (from block), out_ready (to block)
// Modports:
//   master : the environment (upstream source + downstream sink)
//   slave  : the uncrop_pad block
interface uncrop_pad_if #(
    parameter int PIXEL_BIT_WIDTH = 8
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       frame_last;

    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_valid, frame_last
    );

    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_valid, frame_last
    );
endinterface

// File: rtl/raster_pos_counter.sv
// raster_pos_counter - row/col position of a ROWS x COLS raster scan.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset (position -> 0,0)
//   advance    : step to the next raster position this cycle
//   row, col   : current position
//   last       : current position is the final one (ROWS-1, COLS-1)
// The scan wraps from the last position straight back to (0,0).
module raster_pos_counter
    import crop_pkg::*;
#(
    parameter int ROWS = 9,
    parameter int COLS = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         advance,
    output logic [coord_width(ROWS)-1:0] row,
    output logic [coord_width(COLS)-1:0] col,
    output logic                         last
);
    localparam int RW = coord_width(ROWS);
    localparam int CW = coord_width(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    assign last = (row == ROW_MAX) && (col == COL_MAX);

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uncrop_pad.sv
// uncrop_pad - re-embeds a cropped CROP_ROWS x CROP_COLS raster stream into a
// FRAME_ROWS x FRAME_COLS frame at (Y_1, X_1), filling the rest with PAD_VALUE.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : pixel_in/in_valid/in_ready  - cropped input stream
//                 pixel_out/out_valid/out_ready/frame_last - full frame output
//   stall_count : (only with UNCROP_PAD_STALL_CNT_EN) saturating count of cycles
//                 where an in-window pixel could be produced but no input was valid
//
// Optional feature macro: UNCROP_PAD_STALL_CNT_EN
//
// The position counters track the next pixel to produce. Pad pixels are
// generated without consuming input; in-window pixels wait for in_valid.
module uncrop_pad
    import crop_pkg::*;
#(
    parameter int                         PIXEL_BIT_WIDTH = 8,
    parameter int                         CROP_ROWS       = 3,
    parameter int                         CROP_COLS       = 3,
    parameter int                         FRAME_ROWS      = 9,
    parameter int                         FRAME_COLS      = 9,
    parameter int                         Y_1             = 2,
    parameter int                         X_1             = 2,
    parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE       = PIXEL_BIT_WIDTH'(DEFAULT_PAD_VALUE)
) (
    input  logic        clk,
    input  logic        reset,
    uncrop_pad_if.slave bus
`ifdef UNCROP_PAD_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);
    localparam int RW = coord_width(FRAME_ROWS);
    localparam int CW = coord_width(FRAME_COLS);

    if (!window_fits(FRAME_ROWS, Y_1, CROP_ROWS) || !window_fits(FRAME_COLS, X_1, CROP_COLS)) begin : g_bad_window
        $error("uncrop_pad: crop window does not fit inside the frame");
    end

    logic [RW-1:0]              row;
    logic [CW-1:0]              col;
    logic                       last;
    logic                       row_in;
    logic                       col_in;
    logic                       in_win;
    logic                       slot_free;
    logic                       advance;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_q;
    logic                       valid_q;
    logic                       last_q;

    // Compare as signed ints so a window at the origin does not turn into an
    // always-true unsigned compare.
    assign row_in = (int'(row) >= Y_1) && (int'(row) < Y_1 + CROP_ROWS);
    assign col_in = (int'(col) >= X_1) && (int'(col) < X_1 + CROP_COLS);
    assign in_win = row_in && col_in;

    assign slot_free = !valid_q || bus.out_ready;
    // in_ready never looks at in_valid, so upstream may wait on it freely.
    assign bus.in_ready = slot_free && in_win && !reset;
    assign advance      = slot_free && (!in_win || bus.in_valid);

    raster_pos_counter #(
        .ROWS (FRAME_ROWS),
        .COLS (FRAME_COLS)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    // Single output register; it only changes when the slot is free, so a
    // stalled pixel stays stable until downstream takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (advance) begin
            pixel_q <= in_win ? bus.pixel_in : PAD_VALUE;
            valid_q <= 1'b1;
            last_q  <= last;
        end else if (slot_free) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.pixel_out  = pixel_q;
    assign bus.out_valid  = valid_q;
    assign bus.frame_last = last_q;

`ifdef UNCROP_PAD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (slot_free && in_win && !bus.in_valid && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uncrop_pad.sv
// tb_uncrop_pad - scoreboard bench for uncrop_pad.
// Three instances cover a centred 3x3 window (pad 0), a full-frame 9x9
// pass-through, and a 3x3 window at the bottom-right corner with pad 8'hFF.
// Stimulus pushes the expected frame into a per-instance queue; a per-instance
// monitor pops and compares on every output handshake.
module tb_uncrop_pad;
    localparam int NDUT  = 3;
    localparam int LIMIT = 2000;

    localparam int             Y1S   [NDUT] = '{2, 0, 6};
    localparam int             X1S   [NDUT] = '{2, 0, 6};
    localparam int             CRS   [NDUT] = '{3, 9, 3};
    localparam int             CCS   [NDUT] = '{3, 9, 3};
    localparam logic [7:0]     PADS  [NDUT] = '{8'h00, 8'h00, 8'hFF};
    localparam int             BASES [NDUT] = '{1, 0, 160};

    logic       clk = 1'b0;
    logic [7:0] pixel_in   [NDUT];
    logic       in_valid   [NDUT];
    logic       out_ready  [NDUT];
    logic       reset_s    [NDUT];
    logic       in_ready   [NDUT];
    logic       out_valid  [NDUT];
    logic       frame_last [NDUT];
    logic [7:0] pixel_out  [NDUT];
`ifdef UNCROP_PAD_STALL_CNT_EN
    logic [15:0] stall_count [NDUT];
`endif

    logic [8:0] exp_q [NDUT][$];
    int         out_cnt [NDUT];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uncrop_pad_if #(.PIXEL_BIT_WIDTH(8)) bus ();

        assign bus.pixel_in  = pixel_in[g];
        assign bus.in_valid  = in_valid[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign frame_last[g] = bus.frame_last;
        assign pixel_out[g]  = bus.pixel_out;

        uncrop_pad #(
            .PIXEL_BIT_WIDTH (8),
            .CROP_ROWS       (CRS[g]),
            .CROP_COLS       (CCS[g]),
            .FRAME_ROWS      (9),
            .FRAME_COLS      (9),
            .Y_1             (Y1S[g]),
            .X_1             (X1S[g]),
            .PAD_VALUE       (PADS[g])
        ) u_dut (
            .clk         (clk),
            .reset       (reset_s[g]),
            .bus         (bus)
`ifdef UNCROP_PAD_STALL_CNT_EN
            ,
            .stall_count (stall_count[g])
`endif
        );

        // Monitor: scoreboard pops on handshakes, plus a stability check on
        // any pixel that was presented but not taken on the previous cycle.
        bit         held = 1'b0;
        logic [7:0] held_pix;
        logic       held_last;
        logic [8:0] e;

        always @(negedge clk) begin
            if (reset_s[g]) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check($sformatf("d%0d stall valid", g), 32'(out_valid[g]), 32'd1);
                    check($sformatf("d%0d stall pixel", g), 32'(pixel_out[g]), 32'(held_pix));
                    check($sformatf("d%0d stall last", g), 32'(frame_last[g]), 32'(held_last));
                end
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("d%0d unexpected output", g), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("d%0d pixel idx %0d", g, out_cnt[g]), 32'(pixel_out[g]), 32'(e[7:0]));
                        check($sformatf("d%0d last idx %0d", g, out_cnt[g]), 32'(frame_last[g]), 32'(e[8]));
                    end
                    out_cnt[g]++;
                end
                held      = out_valid[g] && !out_ready[g];
                held_pix  = pixel_out[g];
                held_last = frame_last[g];
            end
        end
    end

    // Push one full expected frame, then drive the instance until the frame
    // drains (or stop_after outputs have been taken).
    task automatic run_frame(input int d, input bit rnd, input int stop_after, input int hold_at,
                             input logic [7:0] hold_pix, input int exp_first_rdy, input int exp_cycles);
        int  n, idx, cyc, hs_cnt, first_rdy, hold_left;
        bit  hs, holding;
        logic [7:0] pix;
        n = CRS[d] * CCS[d];
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                if (r >= Y1S[d] && r < Y1S[d] + CRS[d] && c >= X1S[d] && c < X1S[d] + CCS[d])
                    pix = 8'(BASES[d] + (r - Y1S[d]) * CCS[d] + (c - X1S[d]));
                else
                    pix = PADS[d];
                exp_q[d].push_back({(r == 8 && c == 8), pix});
            end
        end
        out_cnt[d] = 0;
        idx = 0; cyc = 0; hs_cnt = 0; first_rdy = -1; hold_left = 5;
        while (exp_q[d].size() != 0 && cyc < LIMIT && (stop_after < 0 || out_cnt[d] < stop_after)) begin
            holding      = (hold_at >= 0) && (out_cnt[d] == hold_at) && (hold_left > 0);
            in_valid[d]  = (idx < n) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            pixel_in[d]  = (idx < n) ? 8'(BASES[d] + idx) : 8'h00;
            out_ready[d] = holding ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            @(negedge clk);
            hs = in_valid[d] && in_ready[d];
            if (in_ready[d] && first_rdy < 0) first_rdy = cyc;
            if (holding) begin
                hold_left--;
                check($sformatf("d%0d hold valid", d), 32'(out_valid[d]), 32'd1);
                check($sformatf("d%0d hold pixel", d), 32'(pixel_out[d]), 32'(hold_pix));
                check($sformatf("d%0d hold in_ready", d), 32'(in_ready[d]), 32'd0);
            end
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                hs_cnt++;
            end
            cyc++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        if (stop_after < 0) begin
            check($sformatf("d%0d frame drained", d), 32'(exp_q[d].size()), 32'd0);
            check($sformatf("d%0d handshakes", d), 32'(hs_cnt), 32'(n));
        end else begin
            exp_q[d].delete();
        end
        if (exp_first_rdy >= 0) check($sformatf("d%0d first in_ready", d), 32'(first_rdy), 32'(exp_first_rdy));
        if (exp_cycles >= 0) check($sformatf("d%0d frame cycles", d), 32'(cyc), 32'(exp_cycles));
    endtask

    task automatic check_reset_state(input int d);
        check($sformatf("d%0d reset out_valid", d), 32'(out_valid[d]), 32'd0);
        check($sformatf("d%0d reset pixel_out", d), 32'(pixel_out[d]), 32'd0);
        check($sformatf("d%0d reset frame_last", d), 32'(frame_last[d]), 32'd0);
        check($sformatf("d%0d reset in_ready", d), 32'(in_ready[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            pixel_in[d]  = 8'h00;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            reset_s[d]   = 1'b1;
            out_cnt[d]   = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_reset_state(d);
        @(posedge clk);
        #1;

        // Centred window: full rate, then random handshakes back to back,
        // then a 5-cycle downstream stall on output index 20.
        reset_s[0] = 1'b0;
        run_frame(0, 1'b0, -1, -1, 8'h00, 20, 82);
        run_frame(0, 1'b1, -1, -1, 8'h00, -1, -1);
        run_frame(0, 1'b0, -1, 20, 8'd1, -1, -1);

        // Reset after 40 outputs: the held pixel is dropped, restart at (0,0).
        run_frame(0, 1'b0, 40, -1, 8'h00, -1, -1);
        reset_s[0] = 1'b1;
        @(posedge clk);
        #1;
        check("d0 mid reset out_valid", 32'(out_valid[0]), 32'd0);
        check("d0 mid reset in_ready", 32'(in_ready[0]), 32'd0);
        reset_s[0] = 1'b0;
        run_frame(0, 1'b0, -1, -1, 8'h00, 20, 82);

        // Crop equal to frame: registered pass-through at 1 pixel/cycle.
        reset_s[1] = 1'b0;
        run_frame(1, 1'b0, -1, -1, 8'h00, 0, 82);

        // Window touching the bottom-right corner, pad 8'hFF.
        reset_s[2] = 1'b0;
        run_frame(2, 1'b0, -1, -1, 8'h00, 60, 82);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
